// File: rtl/sprite_mixer.sv
// rtl/sprite_mixer.sv - three-stage VGA sprite overlay mixer with double-buffered sprite registers
//
// Overlays N_SPR hardware sprites on a background colour. Sprite position and
// visibility are written into shadow registers at any time and copied into
// the active (rendering) registers once per frame, at the first pixel of the
// first blanking row, so a sprite never tears mid-frame.
//
// Ports
//   vga_clk, arst_n          pixel clock, asynchronous active-low reset
//   col_i, row_i             current pixel coordinate from the VGA timing generator
//   disp_ena_i, hs_i, vs_i   display enable and syncs from the VGA timing generator
//   bg_rgb_i                 background colour, RGB444
//   wr_en_i, wr_sel_i        shadow register write strobe and target sprite
//   wr_x_i, wr_y_i, wr_vis_i shadow register write data
//   rom_addr_o               per-sprite ROM address, AW bits per sprite
//   rom_data_i               per-sprite ROM word one cycle later: [15] opaque, [11:0] RGB444
//   r_o, g_o, b_o            mixed colour, 3 cycles after col_i/row_i
//   hs_o, vs_o               syncs delayed by 3 cycles
//   coll_o                   per-sprite collision flags for the last completed frame
//
// Optional feature: define SPRITE_MIXER_COLLISION_EN to build the collision
// accumulator; without it coll_o is tied to 0.

module sprite_mixer #(
    parameter  int N_SPR = 2,
    parameter  int SPR_W = 64,
    parameter  int SPR_H = 64,
    parameter  int H_ACT = 640,
    parameter  int V_ACT = 480,
    localparam int AW    = $clog2(SPR_W * SPR_H)
) (
    input  logic                  vga_clk,
    input  logic                  arst_n,
    input  logic [9:0]            col_i,
    input  logic [8:0]            row_i,
    input  logic                  disp_ena_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    input  logic [11:0]           bg_rgb_i,
    input  logic                  wr_en_i,
    input  logic [2:0]            wr_sel_i,
    input  logic [9:0]            wr_x_i,
    input  logic [8:0]            wr_y_i,
    input  logic                  wr_vis_i,
    output logic [N_SPR*AW-1:0]   rom_addr_o,
    input  logic [N_SPR*16-1:0]   rom_data_i,
    output logic [3:0]            r_o,
    output logic [3:0]            g_o,
    output logic [3:0]            b_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic [N_SPR-1:0]      coll_o
);

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge vga_clk or negedge arst_n) begin
        if (!arst_n) rst_sync_q <= '0;
        else         rst_sync_q <= rst_sync_d;
    end

    assign rst_n = rst_sync_q[1];

    logic commit;
    assign commit = (row_i == 9'(V_ACT)) && (col_i == '0);

    // Shadow and active sprite register sets
    logic [9:0] sh_x_q  [N_SPR];
    logic [9:0] sh_x_d  [N_SPR];
    logic [8:0] sh_y_q  [N_SPR];
    logic [8:0] sh_y_d  [N_SPR];
    logic       sh_v_q  [N_SPR];
    logic       sh_v_d  [N_SPR];
    logic [9:0] act_x_q [N_SPR];
    logic [9:0] act_x_d [N_SPR];
    logic [8:0] act_y_q [N_SPR];
    logic [8:0] act_y_d [N_SPR];
    logic       act_v_q [N_SPR];
    logic       act_v_d [N_SPR];

    // The commit reads the registered shadow value, so a write landing on
    // the commit cycle only reaches the active set one frame later.
    always_comb begin
        for (int i = 0; i < N_SPR; i++) begin
            sh_x_d[i]  = sh_x_q[i];
            sh_y_d[i]  = sh_y_q[i];
            sh_v_d[i]  = sh_v_q[i];
            act_x_d[i] = commit ? sh_x_q[i] : act_x_q[i];
            act_y_d[i] = commit ? sh_y_q[i] : act_y_q[i];
            act_v_d[i] = commit ? sh_v_q[i] : act_v_q[i];
            if (wr_en_i && (wr_sel_i == 3'(i))) begin
                sh_x_d[i] = wr_x_i;
                sh_y_d[i] = wr_y_i;
                sh_v_d[i] = wr_vis_i;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SPR; i++) begin
                sh_x_q[i]  <= '0;
                sh_y_q[i]  <= '0;
                sh_v_q[i]  <= 1'b0;
                act_x_q[i] <= '0;
                act_y_q[i] <= '0;
                act_v_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < N_SPR; i++) begin
                sh_x_q[i]  <= sh_x_d[i];
                sh_y_q[i]  <= sh_y_d[i];
                sh_v_q[i]  <= sh_v_d[i];
                act_x_q[i] <= act_x_d[i];
                act_y_q[i] <= act_y_d[i];
                act_v_q[i] <= act_v_d[i];
            end
        end
    end

    // Stage 1: hit test and ROM address
    logic [10:0]          dx [N_SPR];
    logic [10:0]          dy [N_SPR];
    logic                 in_act;
    logic [N_SPR-1:0]     hit1_d, hit1_q;
    logic [N_SPR*AW-1:0]  addr_d, addr_q;
    logic                 de1_q, hs1_q, vs1_q;
    logic [11:0]          bg1_q;

    // Offsets are 11-bit two's complement; a negative offset (bit 10 set)
    // means the pixel is left of / above the sprite, so nothing wraps.
    always_comb begin
        in_act = (32'(col_i) < H_ACT) && (32'(row_i) < V_ACT);
        hit1_d = '0;
        addr_d = '0;
        for (int i = 0; i < N_SPR; i++) begin
            dx[i] = {1'b0, col_i} - {1'b0, act_x_q[i]};
            dy[i] = {2'b00, row_i} - {2'b00, act_y_q[i]};
            hit1_d[i] = in_act && act_v_q[i] && !dx[i][10] && !dy[i][10] &&
                        (32'(dx[i]) < SPR_W) && (32'(dy[i]) < SPR_H);
            if (hit1_d[i])
                addr_d[i*AW +: AW] = AW'(32'(dy[i]) * SPR_W + 32'(dx[i]));
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            hit1_q <= '0;
            addr_q <= '0;
            de1_q  <= 1'b0;
            hs1_q  <= 1'b0;
            vs1_q  <= 1'b0;
            bg1_q  <= '0;
        end else begin
            hit1_q <= hit1_d;
            addr_q <= addr_d;
            de1_q  <= disp_ena_i;
            hs1_q  <= hs_i;
            vs1_q  <= vs_i;
            bg1_q  <= bg_rgb_i;
        end
    end

    assign rom_addr_o = addr_q;

    // Stage 2: side-band delayed to line up with the ROM read data
    logic [N_SPR-1:0] hit2_q;
    logic             de2_q, hs2_q, vs2_q;
    logic [11:0]      bg2_q;

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            hit2_q <= '0;
            de2_q  <= 1'b0;
            hs2_q  <= 1'b0;
            vs2_q  <= 1'b0;
            bg2_q  <= '0;
        end else begin
            hit2_q <= hit1_q;
            de2_q  <= de1_q;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
            bg2_q  <= bg1_q;
        end
    end

    // Stage 3: priority mix
    logic [N_SPR-1:0] opq_hit;
    logic [11:0]      rgb_d, rgb_q;
    logic             hs3_q, vs3_q;
    logic             unused_rom;

    assign unused_rom = ^rom_data_i;

    // Walk from the highest index down so the lowest-index opaque sprite wins.
    always_comb begin
        opq_hit = '0;
        rgb_d   = bg2_q;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            opq_hit[i] = hit2_q[i] && rom_data_i[i*16 + 15];
            if (opq_hit[i]) rgb_d = rom_data_i[i*16 +: 12];
        end
        if (!de2_q) rgb_d = '0;
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= '0;
            hs3_q <= 1'b0;
            vs3_q <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            hs3_q <= hs2_q;
            vs3_q <= vs2_q;
        end
    end

    assign r_o  = rgb_q[11:8];
    assign g_o  = rgb_q[7:4];
    assign b_o  = rgb_q[3:0];
    assign hs_o = hs3_q;
    assign vs_o = vs3_q;

`ifdef SPRITE_MIXER_COLLISION_EN
    logic [N_SPR-1:0] coll_now;
    logic [N_SPR-1:0] others;
    logic [N_SPR-1:0] acc_d, acc_q;
    logic [N_SPR-1:0] coll_d, coll_q;

    always_comb begin
        coll_now = '0;
        others   = '0;
        for (int i = 0; i < N_SPR; i++) begin
            others      = opq_hit;
            others[i]   = 1'b0;
            coll_now[i] = de2_q && opq_hit[i] && (|others);
        end
        // A collision seen on the commit cycle seeds the new frame.
        acc_d  = commit ? coll_now : (acc_q | coll_now);
        coll_d = commit ? acc_q : coll_q;
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            coll_q <= '0;
        end else begin
            acc_q  <= acc_d;
            coll_q <= coll_d;
        end
    end

    assign coll_o = coll_q;
`else
    assign coll_o = '0;
`endif

endmodule

// File: doc/sprite_mixer.md
SPRITE_MIXER -- requirements
Module: sprite_mixer

Interface
REQ-001 Parameters: N_SPR default 2 (sprite count, 1..8); SPR_W default 64 (sprite width, power of 2); SPR_H default 64 (sprite height); H_ACT default 640 (active columns); V_ACT default 480 (active rows).
REQ-002 vga_clk  in  1  pixel clock, 25 MHz; all logic is on the rising edge.
REQ-003 arst_n  in  1  asynchronous active-low reset.
REQ-004 col_i  in  10  pixel column from the VGA controller.
REQ-005 row_i  in  9  pixel row from the VGA controller.
REQ-006 disp_ena_i, hs_i, vs_i  in  1 each  display enable, horizontal sync and vertical sync from the VGA controller.
REQ-007 bg_rgb_i  in  12  background colour, RGB444.
REQ-008 wr_en_i  in  1  sprite register write strobe.
REQ-009 wr_sel_i  in  3  target sprite index.
REQ-010 wr_x_i  in  10  sprite X position; wr_y_i  in  9  sprite Y position; wr_vis_i  in  1  sprite visible flag.
REQ-011 rom_addr_o  out  N_SPR*log2(SPR_W*SPR_H)  per-sprite ROM address; sprite i uses slice i.
REQ-012 rom_data_i  in  N_SPR*16  per-sprite ROM data, 1-cycle synchronous ROM; bit 15 = opaque, bits [11:0] = RGB444.
REQ-013 r_o, g_o, b_o  out  4 each  mixed colour.
REQ-014 hs_o, vs_o  out  1 each  delayed sync signals.
REQ-015 coll_o  out  N_SPR  per-sprite collision flags for the last completed frame.

Function
REQ-016 Each sprite has two register sets: shadow (x, y, vis), written by wr_en_i, and active, used for rendering.
REQ-017 wr_en_i=1 with wr_sel_i<N_SPR writes the shadow set of that sprite in the same cycle; wr_sel_i>=N_SPR is ignored.
REQ-018 A commit pulse occurs on the cycle where row_i==V_ACT and col_i==0; on that pulse every active set is loaded from its shadow set.
REQ-019 When a write and a commit fall on the same cycle, the commit copies the pre-write shadow value and the new value takes effect at the next commit.
REQ-020 Stage 1: dx=col_i-x and dy=row_i-y are computed as signed 11-bit values.
REQ-021 Stage 1: hit_i is set when vis=1, 0<=dx<SPR_W and 0<=dy<SPR_H; a sprite extending past the screen edge is clipped and never wraps around.
REQ-022 Stage 1: rom_addr_o slice i is registered as dy*SPR_W+dx when hit_i=1, and 0 otherwise.
REQ-023 Stage 2: rom_data_i is valid; hit, disp_ena, hs, vs and bg_rgb are delayed to stay aligned with it.
REQ-024 Stage 3: the colour is that of the lowest-index sprite with hit=1 and opaque=1; if none, it is bg_rgb_i; if the delayed disp_ena is 0, it is 0.
REQ-025 r_o/g_o/b_o, hs_o and vs_o have a fixed latency of 3 vga_clk cycles from col_i/row_i/hs_i/vs_i.
REQ-026 Pixels with opaque=0 are transparent and never win priority.

Reset
REQ-027 arst_n=0 clears all shadow and active registers (x=0, y=0, vis=0), all pipeline stages, r_o/g_o/b_o, coll_o and the collision accumulator to 0.
REQ-028 hs_o and vs_o reset to 0.
REQ-029 Release of reset is synchronised to vga_clk; the first commit after reset loads whatever shadow values were written after release.

Configuration
REQ-030 Macro SPRITE_MIXER_COLLISION_EN defined: a per-sprite accumulator bit i is set at stage 3 when sprite i is opaque-hit at the same pixel as any other opaque-hit sprite while disp_ena=1.
REQ-031 With the macro, at commit coll_o is loaded from the accumulator and the accumulator is cleared; a collision on the commit cycle is counted in the next frame.
REQ-032 Macro SPRITE_MIXER_COLLISION_EN undefined: coll_o is constant 0 and no accumulator logic is synthesised.

Verification
REQ-033 Reset, then sprite 0 written to (100,50), vis=1, opaque ROM; after commit, pixel (100,50) -> r_o/g_o/b_o equal ROM word 0, 3 cycles after col/row; pixel (99,50) -> bg_rgb_i.
REQ-034 Sprite 0 and sprite 1 both at (200,200), both opaque -> sprite 0 colour shown; sprite 0 word transparent -> sprite 1 colour shown.
REQ-035 Sprite at (620,470) -> hits only for col 620..639 and row 470..479; pixel (0,0) shows bg_rgb_i, with no wrap.
REQ-036 Write issued on the commit cycle -> old position rendered for one frame, new position rendered the following frame.
REQ-037 With SPRITE_MIXER_COLLISION_EN, two opaque sprites overlapping -> coll_o=2'b11 after commit; sprites separated -> coll_o=2'b00 one frame later; without the macro -> coll_o=0 always.
REQ-038 arst_n asserted mid-frame -> all outputs are 0 immediately (asynchronously), vis=0, and only background is shown after release.
